// File: rtl/affine_tap_accumulator.sv
// affine_tap_accumulator
// Multi-tap MAC stage that sits after the affine constant-multiplier bank.
// Each accepted beat selects one of 15 constant products (or zero), applies
// the tap sign and adds the result to a signed accumulator. After TAPS beats
// the sum is rounded (ties toward +inf), arithmetically shifted and clipped
// to an unsigned pixel. The pixel is then held in a one-entry output register
// that sits behind a valid/ready handshake.
module affine_tap_accumulator #(
  parameter int TAPS  = 6,
  parameter int ACC_W = 20,
  parameter int SHIFT = 6,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [239:0]       in_prod,
  input  logic [3:0]         coef_sel,
  input  logic               coef_neg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic [ACC_W-1:0]   out_raw,
  output logic [2:0]         tap_cnt
);

  localparam logic [2:0] LAST_TAP = 3'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_ADD =
    {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] PIX_MAX =
    {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic signed [ACC_W-1:0] acc_r;

  logic [15:0]             prod_s;
  logic signed [ACC_W-1:0] ext_s;
  logic signed [ACC_W-1:0] term_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] rnd_s;
  logic signed [ACC_W-1:0] raw_s;
  logic [PIX_W-1:0]        pix_s;
  logic                    last_s;
  logic                    accept_s;
  logic                    drain_s;

  // Pick the product addressed by coef_sel; selector 0 yields a zero tap.
  always_comb begin
    prod_s = 16'h0000;
    for (int k = 1; k <= 15; k++) begin
      prod_s = prod_s | ((coef_sel == 4'(k)) ? in_prod[16*(k-1) +: 16] : 16'h0000);
    end
  end

  // Sign-extend, apply tap sign, then form the rounded/shifted/clipped result.
  always_comb begin
    ext_s  = {{(ACC_W-16){prod_s[15]}}, prod_s};
    term_s = coef_neg ? (-ext_s) : ext_s;
    sum_s  = acc_r + term_s;
    rnd_s  = sum_s + RND_ADD;
    raw_s  = rnd_s >>> SHIFT;
    if (raw_s < $signed({ACC_W{1'b0}})) begin
      pix_s = {PIX_W{1'b0}};
    end else if (raw_s > PIX_MAX) begin
      pix_s = {PIX_W{1'b1}};
    end else begin
      pix_s = raw_s[PIX_W-1:0];
    end
  end

  // Handshake qualifiers: only the last beat can be stalled by a full output register.
  always_comb begin
    last_s = (tap_cnt == LAST_TAP);
    if (last_s) begin
      in_ready = (!out_valid) || out_ready;
    end else begin
      in_ready = 1'b1;
    end
    accept_s = in_valid && in_ready && !flush;
    drain_s  = out_valid && out_ready;
  end

  // Accumulator and tap counter; flush drops the partial pixel and any same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {ACC_W{1'b0}};
      tap_cnt <= 3'd0;
    end else if (flush) begin
      acc_r   <= {ACC_W{1'b0}};
      tap_cnt <= 3'd0;
    end else if (accept_s) begin
      if (last_s) begin
        acc_r   <= {ACC_W{1'b0}};
        tap_cnt <= 3'd0;
      end else begin
        acc_r   <= sum_s;
        tap_cnt <= tap_cnt + 3'd1;
      end
    end else begin
      acc_r   <= acc_r;
      tap_cnt <= tap_cnt;
    end
  end

  // One-entry output register: loads on last beat, clears on drain, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= {PIX_W{1'b0}};
      out_raw   <= {ACC_W{1'b0}};
    end else if (accept_s && last_s) begin
      out_valid <= 1'b1;
      out_pix   <= pix_s;
      out_raw   <= raw_s;
    end else if (drain_s) begin
      out_valid <= 1'b0;
      out_pix   <= out_pix;
      out_raw   <= out_raw;
    end else begin
      out_valid <= out_valid;
      out_pix   <= out_pix;
      out_raw   <= out_raw;
    end
  end

endmodule

// File: tb/tb_affine_tap_accumulator.sv
// Directed testbench for affine_tap_accumulator (TAPS=6, ACC_W=20, SHIFT=6, PIX_W=8).
module tb_affine_tap_accumulator;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [239:0] in_prod;
  logic [3:0]   coef_sel;
  logic         coef_neg;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_pix;
  logic [19:0]  out_raw;
  logic [2:0]   tap_cnt;

  int n_cmp;
  int n_bad;

  affine_tap_accumulator #(
    .TAPS(6), .ACC_W(20), .SHIFT(6), .PIX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .coef_sel(coef_sel), .coef_neg(coef_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_raw(out_raw), .tap_cnt(tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product vector: chosen slot carries val, every other slot carries a
  // distinct nonzero filler so a wrong selection shows up in the result.
  function automatic logic [239:0] mk_prod(input int sel, input int val);
    logic [239:0] p;
    logic [15:0]  v;
    for (int k = 0; k < 15; k++) begin
      p[16*k +: 16] = 16'(1000 + 37 * k);
    end
    v = 16'(val);
    if (sel != 0) p[16*(sel-1) +: 16] = v;
    return p;
  endfunction

  // Present one beat for a single clock edge (stimulus only), then idle.
  task automatic put_beat(input int sel, input bit neg, input int val);
    in_valid = 1'b1;
    coef_sel = 4'(sel);
    coef_neg = neg;
    in_prod  = mk_prod(sel, val);
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_sel = 4'd0;
    coef_neg = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    coef_sel = 4'd0; coef_neg = 1'b0; in_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0d want=0", out_valid); end
    n_cmp++; if (out_pix !== 8'd0) begin n_bad++; $display("FAIL reset_out_pix got=%0d want=0", out_pix); end
    n_cmp++; if (out_raw !== 20'd0) begin n_bad++; $display("FAIL reset_out_raw got=%0d want=0", out_raw); end
    n_cmp++; if (tap_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_tap_cnt got=%0d want=0", tap_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drain a pending pixel with one out_ready pulse and confirm it leaves.
  task automatic drain(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drain out_valid got=%0d want=0", nm, out_valid); end
  endtask

  task automatic test_basic;
    put_beat(13, 1'b0, 6000);
    n_cmp++; if (tap_cnt !== 3'd1) begin n_bad++; $display("FAIL basic_tap1 got=%0d want=1", tap_cnt); end
    put_beat(1, 1'b0, 400);
    for (int i = 0; i < 3; i++) put_beat(0, 1'b0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%0d want=0", out_valid); end
    n_cmp++; if (tap_cnt !== 3'd5) begin n_bad++; $display("FAIL basic_tap5 got=%0d want=5", tap_cnt); end
    put_beat(0, 1'b0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0d want=1", out_valid); end
    n_cmp++; if (out_pix !== 8'd100) begin n_bad++; $display("FAIL basic_pix got=%0d want=100", out_pix); end
    n_cmp++; if (out_raw !== 20'd100) begin n_bad++; $display("FAIL basic_raw got=%0d want=100", $signed(out_raw)); end
    n_cmp++; if (tap_cnt !== 3'd0) begin n_bad++; $display("FAIL basic_tap_wrap got=%0d want=0", tap_cnt); end
    drain("basic");
  endtask

  task automatic test_neg_clip;
    put_beat(15, 1'b0, -8000);
    put_beat(15, 1'b1, 100);
    for (int i = 0; i < 4; i++) put_beat(0, 1'b0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL negclip_valid got=%0d want=1", out_valid); end
    n_cmp++; if ($signed(out_raw) !== -20'sd127) begin n_bad++; $display("FAIL negclip_raw got=%0d want=-127", $signed(out_raw)); end
    n_cmp++; if (out_pix !== 8'd0) begin n_bad++; $display("FAIL negclip_pix got=%0d want=0", out_pix); end
    drain("negclip");
  endtask

  task automatic test_high_clip;
    for (int i = 0; i < 6; i++) put_beat(15, 1'b0, 8001);
    n_cmp++; if (out_raw !== 20'd750) begin n_bad++; $display("FAIL hiclip_raw got=%0d want=750", $signed(out_raw)); end
    n_cmp++; if (out_pix !== 8'd255) begin n_bad++; $display("FAIL hiclip_pix got=%0d want=255", out_pix); end
    drain("hiclip");
  endtask

  task automatic test_backpressure;
    // Pixel A = 100, left pending with out_ready low.
    put_beat(13, 1'b0, 6000);
    put_beat(1, 1'b0, 400);
    for (int i = 0; i < 4; i++) put_beat(0, 1'b0, 0);
    // Pixel B beats 1..5 = 8001 each; in_ready must stay high.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; coef_sel = 4'd15; coef_neg = 1'b0; in_prod = mk_prod(15, 8001);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_beat%0d got=%0d want=1", i + 1, in_ready); end
      @(posedge clk); #1;
    end
    // Beat 6 presented while A is still pending: stalled.
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_beat6 got=%0d want=0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_pix !== 8'd100) begin n_bad++; $display("FAIL bp_hold_pix got=%0d want=100", out_pix); end
    n_cmp++; if (out_raw !== 20'd100) begin n_bad++; $display("FAIL bp_hold_raw got=%0d want=100", $signed(out_raw)); end
    n_cmp++; if (tap_cnt !== 3'd5) begin n_bad++; $display("FAIL bp_hold_tap got=%0d want=5", tap_cnt); end
    // Release: A drains and B loads on the same edge.
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release got=%0d want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_stays got=%0d want=1", out_valid); end
    n_cmp++; if (out_pix !== 8'd255) begin n_bad++; $display("FAIL bp_pix_b got=%0d want=255", out_pix); end
    n_cmp++; if (out_raw !== 20'd750) begin n_bad++; $display("FAIL bp_raw_b got=%0d want=750", $signed(out_raw)); end
    n_cmp++; if (tap_cnt !== 3'd0) begin n_bad++; $display("FAIL bp_tap_b got=%0d want=0", tap_cnt); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_b got=%0d want=0", out_valid); end
  endtask

  task automatic test_flush;
    int npix;
    for (int i = 0; i < 3; i++) put_beat(15, 1'b0, 5000);
    n_cmp++; if (tap_cnt !== 3'd3) begin n_bad++; $display("FAIL flush_pre_tap got=%0d want=3", tap_cnt); end
    flush = 1'b1;
    put_beat(15, 1'b0, 5000);
    flush = 1'b0;
    n_cmp++; if (tap_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_tap got=%0d want=0", tap_cnt); end
    out_ready = 1'b1;
    npix = 0;
    put_beat(13, 1'b0, 6000); if (out_valid) npix++;
    put_beat(1, 1'b0, 400);   if (out_valid) npix++;
    for (int i = 0; i < 3; i++) begin put_beat(0, 1'b0, 0); if (out_valid) npix++; end
    put_beat(0, 1'b0, 0);
    n_cmp++; if (out_pix !== 8'd100) begin n_bad++; $display("FAIL flush_pix got=%0d want=100", out_pix); end
    n_cmp++; if (out_raw !== 20'd100) begin n_bad++; $display("FAIL flush_raw got=%0d want=100", $signed(out_raw)); end
    if (out_valid) npix++;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (out_valid) npix++; end
    out_ready = 1'b0;
    n_cmp++; if (npix !== 1) begin n_bad++; $display("FAIL flush_pixel_count got=%0d want=1", npix); end
  endtask

  task automatic test_async_reset;
    // Pending pixel of 100, then three beats of a second pixel.
    put_beat(13, 1'b0, 6000);
    put_beat(1, 1'b0, 400);
    for (int i = 0; i < 4; i++) put_beat(0, 1'b0, 0);
    for (int i = 0; i < 3; i++) put_beat(15, 1'b0, 3000);
    // Beat 4 in flight when reset hits mid-cycle.
    in_valid = 1'b1; coef_sel = 4'd15; in_prod = mk_prod(15, 3000);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got=%0d want=0", out_valid); end
    n_cmp++; if (tap_cnt !== 3'd0) begin n_bad++; $display("FAIL arst_tap_cnt got=%0d want=0", tap_cnt); end
    in_valid = 1'b0; coef_sel = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Six beats of 100: (600 + 32) >> 6 = 9.
    for (int i = 0; i < 6; i++) put_beat(15, 1'b0, 100);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_next_valid got=%0d want=1", out_valid); end
    n_cmp++; if (out_pix !== 8'd9) begin n_bad++; $display("FAIL arst_next_pix got=%0d want=9", out_pix); end
    n_cmp++; if (out_raw !== 20'd9) begin n_bad++; $display("FAIL arst_next_raw got=%0d want=9", $signed(out_raw)); end
    drain("arst");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_neg_clip();
    test_high_clip();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached got=running want=finished");
    $fatal(1);
  end

endmodule
